// File: rtl/ppu_pattern_fetch.sv
// ppu_pattern_fetch
// Fetches one CHR pattern row for the renderer: it issues the plane-0 and
// plane-1 addresses on the PPU bus, captures the registered memory read data,
// optionally bit-reverses both bytes (H-flip), and presents the pair through a
// valid/ready output. MEM_LATENCY (1..3) is the number of ppu_clk edges
// between the memory sampling ppu_ab and ppu_do holding that data.
module ppu_pattern_fetch #(
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic        ppu_clk,
    input  logic        ppu_rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_table,
    input  logic [7:0]  req_tile,
    input  logic [2:0]  req_fine_y,
    input  logic        req_hflip,
    output logic [13:0] ppu_ab,
    output logic        ppu_rd,
    input  logic [7:0]  ppu_do,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_lo,
    output logic [7:0]  out_hi
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_ISSUE_HI = 2'd1;
    localparam logic [1:0] ST_WAIT     = 2'd2;

    // Counter values (counter loads 1 on the ISSUE_HI edge) at which the
    // low and high plane bytes are present on ppu_do.
    localparam logic [2:0] CAP_LO = 3'(MEM_LATENCY);
    localparam logic [2:0] CAP_HI = 3'(MEM_LATENCY + 1);

    logic [1:0]  state_q,     state_d;
    logic        table_q,     table_d;
    logic [7:0]  tile_q,      tile_d;
    logic [2:0]  fine_y_q,    fine_y_d;
    logic        hflip_q,     hflip_d;
    logic [13:0] ab_q,        ab_d;
    logic        rd_q,        rd_d;
    logic [2:0]  cnt_q,       cnt_d;
    logic [7:0]  lo_q,        lo_d;
    logic        out_valid_q, out_valid_d;
    logic [7:0]  out_lo_q,    out_lo_d;
    logic [7:0]  out_hi_q,    out_hi_d;
    logic        complete;

    function automatic logic [7:0] bit_rev(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = v[7-i];
        end
        return r;
    endfunction

    // A new request may start once the output slot is free or being drained this edge.
    assign req_ready = (state_q == ST_IDLE) && (!out_valid_q || out_ready);

    // Next-state logic for the fetch sequencer and the output register.
    always_comb begin
        // NOTE: every _d gets its hold value first so no path through the case leaves it unassigned (no latch).
        state_d     = state_q;
        table_d     = table_q;
        tile_d      = tile_q;
        fine_y_d    = fine_y_q;
        hflip_d     = hflip_q;
        ab_d        = ab_q;
        rd_d        = rd_q;
        cnt_d       = cnt_q;
        lo_d        = lo_q;
        out_valid_d = out_valid_q;
        out_lo_d    = out_lo_q;
        out_hi_d    = out_hi_q;
        complete    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    table_d  = req_table;
                    tile_d   = req_tile;
                    fine_y_d = req_fine_y;
                    hflip_d  = req_hflip;
                    ab_d     = {1'b0, req_table, req_tile, 1'b0, req_fine_y};
                    rd_d     = 1'b1;
                    state_d  = ST_ISSUE_HI;
                end
            end
            ST_ISSUE_HI: begin
                ab_d    = {1'b0, table_q, tile_q, 1'b1, fine_y_q};
                cnt_d   = 3'd1;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q == CAP_LO) begin
                    lo_d = ppu_do;
                end
                if (cnt_q == CAP_HI) begin
                    complete = 1'b1;
                    rd_d     = 1'b0;
                    state_d  = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A completion wins over a consume landing on the same edge.
        if (complete) begin
            out_valid_d = 1'b1;
            out_lo_d    = hflip_q ? bit_rev(lo_q)   : lo_q;
            out_hi_d    = hflip_q ? bit_rev(ppu_do) : ppu_do;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers; an asynchronous reset abandons any fetch in flight.
    always_ff @(posedge ppu_clk or negedge ppu_rst_n) begin
        if (!ppu_rst_n) begin
            state_q     <= ST_IDLE;
            table_q     <= 1'b0;
            tile_q      <= 8'd0;
            fine_y_q    <= 3'd0;
            hflip_q     <= 1'b0;
            ab_q        <= 14'd0;
            rd_q        <= 1'b0;
            cnt_q       <= 3'd0;
            lo_q        <= 8'd0;
            out_valid_q <= 1'b0;
            out_lo_q    <= 8'd0;
            out_hi_q    <= 8'd0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values computed above.
            state_q     <= state_d;
            table_q     <= table_d;
            tile_q      <= tile_d;
            fine_y_q    <= fine_y_d;
            hflip_q     <= hflip_d;
            ab_q        <= ab_d;
            rd_q        <= rd_d;
            cnt_q       <= cnt_d;
            lo_q        <= lo_d;
            out_valid_q <= out_valid_d;
            out_lo_q    <= out_lo_d;
            out_hi_q    <= out_hi_d;
        end
    end

    assign ppu_ab    = ab_q;
    assign ppu_rd    = rd_q;
    assign out_valid = out_valid_q;
    assign out_lo    = out_lo_q;
    assign out_hi    = out_hi_q;

endmodule
